// File: rtl/cla_pkg.sv
// Shared types and helpers for the nibble-serial carry-lookahead adder family.
package cla_pkg;

  localparam int NIBBLE = 4;

  typedef logic [NIBBLE-1:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int nibbles(input int width);
    return width / NIBBLE;
  endfunction

endpackage

// File: rtl/cla_carry_4.sv
// 4-bit lookahead carry unit, fully two-level expanded, with group G/P outputs.
module cla_carry_4
  import cla_pkg::*;
(
  input  nibble_t    i_g,
  input  nibble_t    i_p,
  input  logic       i_c0,
  output logic [4:1] o_c,
  output logic       o_gg,
  output logic       o_pg
);

  assign o_c[1] = i_g[0] | (i_p[0] & i_c0);
  assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c0);
  assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                | (i_p[2] & i_p[1] & i_p[0] & i_c0);
  assign o_c[4] = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
                | (i_p[3] & i_p[2] & i_p[1] & i_g[0])
                | (i_p[3] & i_p[2] & i_p[1] & i_p[0] & i_c0);

  assign o_gg = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
              | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
  assign o_pg = &i_p;

endmodule

// File: rtl/cla_gp_4.sv
// 4-bit generate/propagate precompute stage feeding a lookahead carry unit.
module cla_gp_4
  import cla_pkg::*;
(
  input  nibble_t i_a,
  input  nibble_t i_b,
  output nibble_t o_g,
  output nibble_t o_p
);

  // OR-propagate: only valid for carries, never for the sum bit.
  assign o_g = i_a & i_b;
  assign o_p = i_a | i_b;

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// Sequential WIDTH-bit adder: one nibble per clock through a 4-bit CLA, LSB first.
module cla_nibble_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int NIB  = nibbles(WIDTH);
  localparam int CNTW = $clog2(NIB) + 1;

  if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_width_check
    $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  sumSh_q, sumSh_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;

  nibble_t           nibA, nibB, gen, prop, sumNib;
  logic [4:1]        carry;
  logic [1:0]        unused_grp;
  logic [WIDTH+3:0]  extSum;

  assign nibA = a_q[NIBBLE-1:0];
  assign nibB = b_q[NIBBLE-1:0];

  cla_gp_4 u_gp (
    .i_a (nibA),
    .i_b (nibB),
    .o_g (gen),
    .o_p (prop)
  );

  cla_carry_4 u_carry (
    .i_g  (gen),
    .i_p  (prop),
    .i_c0 (carry_q),
    .o_c  (carry),
    .o_gg (unused_grp[1]),
    .o_pg (unused_grp[0])
  );

  // Sum bits use the true XOR propagate; the new nibble enters at the MSB end.
  assign sumNib = nibA ^ nibB ^ {carry[3:1], carry_q};
  assign extSum = {sumNib, sumSh_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sumSh_d = sumSh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          a_d     = i_a;
          b_d     = i_b;
          carry_d = i_cin;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> NIBBLE;
        b_d     = b_q >> NIBBLE;
        sumSh_d = extSum[WIDTH+NIBBLE-1:NIBBLE];
        carry_d = carry[4];
        cnt_d   = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(NIB - 1)) begin
          sum_d   = extSum[WIDTH+NIBBLE-1:NIBBLE];
          cout_d  = carry[4];
          ovf_d   = carry[3] ^ carry[4];
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sumSh_q <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sumSh_q <= sumSh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;
  assign o_ovf   = ovf_q;

endmodule
